enigma_rotor_stepper: RTL

- Sequential position controller feeding the `rotate` inputs of the three rotor stages and their inverses (rotor1/rotor1_inv, rotor2/rotor2_inv, rotor3/rotor3_inv).
- On each accepted keypress it advances the rotor offsets with Enigma notch/turnover rules, holds them stable for a settle window while the combinational rotor path resolves, then signals completion.
- Also supports loading operator-selected start positions.

---
 rtl/enigma_rotor_stepper.sv | 122 ++++++++++++
 1 files changed

// File: rtl/enigma_rotor_stepper.sv
// Enigma rotor position controller: steps rot1..rot3 per keypress with notch rules,
// holds them for a settle window, then pulses step_done. ENIGMA_DOUBLE_STEP_EN selects historical double-step.
module enigma_rotor_stepper #(
  parameter int unsigned NOTCH3        = 21,
  parameter int unsigned NOTCH2        = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       load,
  input  logic [4:0] load_pos1,
  input  logic [4:0] load_pos2,
  input  logic [4:0] load_pos3,
  output logic [4:0] rot1,
  output logic [4:0] rot2,
  output logic [4:0] rot3,
  output logic       step_done
);

  localparam int unsigned PW = 5;
  localparam int unsigned CW = 4;
  localparam logic [PW-1:0] LAST_POS = PW'(25);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            by_step_q, by_step_d;
  logic [PW-1:0]   rot1_d, rot2_d, rot3_d;
  logic            key_ready_d, step_done_d;
  logic            hit3, hit2, step2, step1;

  function automatic logic [PW-1:0] pos_inc(input logic [PW-1:0] p);
    return (p == LAST_POS) ? '0 : p + PW'(1);
  endfunction

  // Operator start positions 26..31 fold back onto 0..5.
  function automatic logic [PW-1:0] pos_fold(input logic [PW-1:0] p);
    return (p > LAST_POS) ? p - PW'(26) : p;
  endfunction

  assign hit3 = (rot3 == PW'(NOTCH3));
  assign hit2 = (rot2 == PW'(NOTCH2));

`ifdef ENIGMA_DOUBLE_STEP_EN
  assign step2 = hit3 | hit2;
  assign step1 = hit2;
`else
  assign step2 = hit3;
  assign step1 = hit2 & hit3;
`endif

  // Next-state and next-output logic; load overrides everything, including a pending step.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    by_step_d = by_step_q;
    rot1_d    = rot1;
    rot2_d    = rot2;
    rot3_d    = rot3;

    if (load) begin
      rot1_d    = pos_fold(load_pos1);
      rot2_d    = pos_fold(load_pos2);
      rot3_d    = pos_fold(load_pos3);
      state_d   = SETTLE;
      cnt_d     = CNT_INIT;
      by_step_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_valid) begin
            rot3_d    = pos_inc(rot3);
            rot2_d    = step2 ? pos_inc(rot2) : rot2;
            rot1_d    = step1 ? pos_inc(rot1) : rot1;
            state_d   = SETTLE;
            cnt_d     = CNT_INIT;
            by_step_d = 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_d = by_step_q ? DONE : IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    key_ready_d = (state_d == IDLE);
    step_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      by_step_q <= 1'b0;
      rot1      <= '0;
      rot2      <= '0;
      rot3      <= '0;
      key_ready <= 1'b1;
      step_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      by_step_q <= by_step_d;
      rot1      <= rot1_d;
      rot2      <= rot2_d;
      rot3      <= rot3_d;
      key_ready <= key_ready_d;
      step_done <= step_done_d;
    end
  end

endmodule
